// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks the ROM from fetch_pc, buffers {pc, word} in a small
// prefetch FIFO and presents the head to decode over valid/ready, with redirect flush.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  ST_IDLE  | fetching paused; FIFO may still drain to the core
//  ST_FETCH | one ROM word pushed per cycle while the FIFO has room
//  ST_ERR   | misaligned redirect seen; no fetch until an aligned redirect
module fetch_sequencer #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic [ADDR_WIDTH-1:0]   rom_addr,
  input  logic [DATA_WIDTH-1:0]   rom_data,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [DATA_WIDTH-1:0]   instr,
  output logic [ADDR_WIDTH-1:0]   instr_pc,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic                    fetch_err,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic                   pop, push;

  logic [DATA_WIDTH-1:0]  data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      err_q      <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      err_q      <= err_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      data_mem[wr_ptr_q] <= rom_data;
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    err_d      = err_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    pop  = (count_q != '0) && instr_ready && !redirect_valid;
    push = (state_q == ST_FETCH) && !redirect_valid && ((count_q < FULL) || pop);

    if (redirect_valid) begin
      // Flush drops the presented head even if the core is ready for it.
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_d = redirect_pc;
        err_d      = 1'b0;
        state_d    = enable ? ST_FETCH : ST_IDLE;
      end else begin
        err_d   = 1'b1;
        state_d = ST_ERR;
      end
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      case (state_q)
        ST_IDLE:  if (enable)  state_d = ST_FETCH;
        ST_FETCH: if (!enable) state_d = ST_IDLE;
        ST_ERR:   state_d = ST_ERR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign rom_addr    = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr_q] : '0;
  assign fetch_err   = err_q;
  assign state       = state_q;
  assign fifo_count  = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a queue-based reference model predicts pushes and
// status; a negedge monitor pops expected {pc, word} entries on every accepted instruction.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] w;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n, enable, instr_ready, redirect_valid;
  logic [7:0]  redirect_pc;
  logic [7:0]  rom_addr, instr_pc;
  logic [31:0] rom_data, instr;
  logic        instr_valid, fetch_err;
  logic [1:0]  state;
  logic [1:0]  fifo_count;

  int checks = 0;
  int failures = 0;

  ent_t exp_q[$];
  ent_t acc[$];
  int   m_state, m_count, m_pc;
  bit   m_err, m_rst, started;

  always #5 clk = ~clk;

  fetch_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rom_addr(rom_addr), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_err(fetch_err),
    .state(state), .fifo_count(fifo_count)
  );

  function automatic logic [31:0] rom_fn(input logic [7:0] a);
    case (a)
      8'h00:   return 32'h00052503;
      8'h04:   return 32'h0085a583;
      8'h08:   return 32'h00a58633;
      8'h0C:   return 32'h00c586b3;
      8'h10:   return 32'h02b60063;
      8'h14:   return 32'h40b606b3;
      8'h18:   return 32'h00000013;
      8'h1C:   return 32'h00008067;
      default: return 32'h0;
    endcase
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the inputs sampled at the edge just passed.
  task automatic model_step();
    bit pop, push;
    m_rst = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_pc = 0; m_count = 0; m_err = 1'b0; m_rst = 1'b1;
      exp_q.delete();
    end else if (redirect_valid) begin
      exp_q.delete();
      m_count = 0;
      if (redirect_pc % 4 == 0) begin
        m_pc = redirect_pc; m_err = 1'b0; m_state = enable ? 1 : 0;
      end else begin
        m_err = 1'b1; m_state = 2;
      end
    end else begin
      pop  = (m_count > 0) && instr_ready;
      push = (m_state == 1) && ((m_count < 2) || pop);
      if (pop) m_count--;
      if (push) begin
        exp_q.push_back('{pc: 8'(m_pc), w: rom_fn(8'(m_pc))});
        m_count++;
        m_pc = (m_pc + 4) % 256;
      end
      if (m_state == 0 && enable) m_state = 1;
      else if (m_state == 1 && !enable) m_state = 0;
    end
    started = 1'b1;
  endtask

  task automatic drive(input logic r, input logic e, input logic rd, input logic v,
                       input logic [7:0] p);
    @(posedge clk);
    #1;
    model_step();
    rst_n = r; enable = e; instr_ready = rd; redirect_valid = v; redirect_pc = p;
  endtask

  task automatic expect_acc(input int i, input logic [7:0] pc, input logic [31:0] w);
    checks++;
    if (acc.size() <= i) begin
      failures++;
      $display("FAIL accepted_%0d: got none expected pc %h instr %h", i, pc, w);
    end else if (acc[i].pc !== pc || acc[i].w !== w) begin
      failures++;
      $display("FAIL accepted_%0d: got pc %h instr %h expected pc %h instr %h",
               i, acc[i].pc, acc[i].w, pc, w);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("instr_valid", 32'(instr_valid), 32'(m_count != 0));
      chk("fifo_count", 32'(fifo_count), 32'(m_count));
      chk("state", 32'(state), 32'(m_state));
      chk("fetch_err", 32'(fetch_err), 32'(m_err));
      chk("rom_addr", 32'(rom_addr), 32'(m_pc));
      if (m_rst) begin
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_pc", 32'(instr_pc), 32'h0);
      end
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL handshake: got pc %h instr %h expected no instruction", instr_pc, instr);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if (e.pc !== instr_pc || e.w !== instr) begin
            failures++;
            $display("FAIL handshake: got pc %h instr %h expected pc %h instr %h",
                     instr_pc, instr, e.pc, e.w);
          end
          acc.push_back('{pc: instr_pc, w: instr});
        end
      end
    end
  end

  initial begin
    started = 1'b0;
    rst_n = 1'b0; enable = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h0;

    // Reset, then free-running stream
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 1, 1, 0, 8'h00);
    acc.delete();
    for (int i = 0; i < 6; i++) drive(1, 1, 1, 0, 8'h00);
    expect_acc(0, 8'h00, 32'h00052503);
    expect_acc(1, 8'h04, 32'h0085a583);
    expect_acc(2, 8'h08, 32'h00a58633);

    // Back-pressure from a fresh start
    drive(0, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h00);
    acc.delete();
    for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 8'h00);
    expect_acc(0, 8'h00, 32'h00052503);
    expect_acc(1, 8'h04, 32'h0085a583);
    expect_acc(2, 8'h08, 32'h00a58633);

    // Redirect while full: head dropped
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 8'h00);
    drive(1, 1, 1, 1, 8'h10);
    acc.delete();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 8'h00);
    expect_acc(0, 8'h10, 32'h02b60063);
    expect_acc(1, 8'h14, 32'h40b606b3);

    // Misaligned redirect, then recovery
    drive(1, 1, 1, 1, 8'h12);
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 0, 8'h00);
    drive(1, 1, 1, 1, 8'h14);
    acc.delete();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 8'h00);
    expect_acc(0, 8'h14, 32'h40b606b3);

    // PC wrap at top of address space
    drive(1, 1, 1, 1, 8'hFC);
    acc.delete();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 8'h00);
    expect_acc(0, 8'hFC, 32'h0);
    expect_acc(1, 8'h00, 32'h00052503);

    // Reset mid-operation with a full FIFO
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h00);
    drive(1, 1, 1, 0, 8'h00);
    acc.delete();
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 8'h00);
    expect_acc(0, 8'h00, 32'h00052503);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] p;
      if ($urandom_range(0, 3) == 0) p = 8'($urandom);
      else if ($urandom_range(0, 7) == 0) p = 8'hFC;
      else p = {3'b000, 3'($urandom_range(0, 7)), 2'b00};
      drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), p);
      if (acc.size() > 64) acc.delete();
    end

    drive(1, 0, 1, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
